// File: rtl/ps2_key_event_rx_pkg.sv
// Shared PS/2 constants, prefix FSM states and the queued key-event record.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;
    localparam logic [7:0]  PS2_REL_CODE   = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_REL,
        ST_EXT_REL
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO with occupancy count; a push while full is dropped unless a pop frees the slot.
module ps2_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    assign w_wr    = i_push & (~w_full | w_pop);
    assign o_drop  = i_push & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // When full, a simultaneous push overwrites the head slot only after it has been read out.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_data;
    end

    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes bytes, folds E0/F0 prefixes into events, queues them.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned TIMEOUT_US  = 120,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            rd_en,
    input  logic                            clr_ovf,
    output logic                            ev_valid,
    output logic [7:0]                      ev_code,
    output logic                            ev_ext,
    output logic                            ev_rel,
    output logic                            frame_err,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] ev_count
);

    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0]    r_clk_sync;
    logic [SYNC_STAGES-1:0]    r_data_sync;
    logic                      r_clk_prev;
    logic [PS2_FRAME_BITS-1:0] r_shift;
    logic [3:0]                r_bit_cnt;
    logic [TW-1:0]             r_timer;
    logic                      r_frame_done;
    logic                      r_frame_ok;
    logic [7:0]                r_byte;
    logic                      r_timeout;
    ps2_state_e                r_state;
    logic                      r_overflow;

    logic       w_clk_s;
    logic       w_data_s;
    logic       w_clk_fall;
    logic       w_clk_edge;
    logic       w_timer_sat;
    logic       w_frame_ok;
    ps2_state_e w_state_next;
    logic       w_push;
    logic       w_frame_err;
    ps2_event_t w_event;
    ps2_event_t w_head;
    logic       w_drop;

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_clk_fall  = r_clk_prev & ~w_clk_s;
    assign w_clk_edge  = r_clk_prev ^ w_clk_s;
    assign w_timer_sat = (r_timer == TW'(TIMEOUT_CYC));
    assign w_frame_ok  = ~r_shift[0] & r_shift[PS2_FRAME_BITS-1] & (^r_shift[9:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    // A completed frame is registered once before the prefix FSM sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_timer      <= '0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_byte       <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_timeout    <= 1'b0;
            if (w_clk_edge)        r_timer <= '0;
            else if (!w_timer_sat) r_timer <= r_timer + 1'b1;

            if (r_bit_cnt == 4'(PS2_FRAME_BITS)) begin
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b1;
                r_frame_ok   <= w_frame_ok;
                r_byte       <= r_shift[8:1];
            end else if (w_clk_fall) begin
                r_shift   <= {w_data_s, r_shift[PS2_FRAME_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_timer_sat && (r_bit_cnt != '0) && w_clk_s) begin
                r_bit_cnt <= '0;
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_drop)       r_overflow <= 1'b1;
            else if (clr_ovf) r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        w_event.ext  = (r_state == ST_EXT) || (r_state == ST_EXT_REL);
        w_event.rel  = (r_state == ST_REL) || (r_state == ST_EXT_REL);
        w_event.code = r_byte;
        if (r_timeout) begin
            w_state_next = ST_IDLE;
        end else if (r_frame_done) begin
            if (!r_frame_ok) begin
                w_frame_err  = 1'b1;
                w_state_next = ST_IDLE;
            end else if (r_byte == PS2_EXT_CODE) begin
                if (r_state == ST_IDLE) w_state_next = ST_EXT;
            end else if (r_byte == PS2_REL_CODE) begin
                case (r_state)
                    ST_IDLE: w_state_next = ST_REL;
                    ST_EXT:  w_state_next = ST_EXT_REL;
                    default: w_state_next = r_state;
                endcase
            end else begin
                w_push       = 1'b1;
                w_state_next = ST_IDLE;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(ps2_event_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_event),
        .i_pop   (rd_en),
        .o_valid (ev_valid),
        .o_data  (w_head),
        .o_count (ev_count),
        .o_drop  (w_drop)
    );

    assign ev_code   = w_head.code;
    assign ev_ext    = w_head.ext;
    assign ev_rel    = w_head.rel;
    assign frame_err = w_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed PS/2 frames with a scoreboard queue; a negedge monitor pops and compares head events.
`timescale 1ns/1ps
module tb_ps2_key_event_rx;

    localparam int unsigned S     = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int          HALF  = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          ps2_clk;
    logic          ps2_data;
    logic          rd_en = 1'b0;
    logic          clr_ovf;
    logic          ev_valid;
    logic [7:0]    ev_code;
    logic          ev_ext;
    logic          ev_rel;
    logic          frame_err;
    logic          overflow;
    logic [CW-1:0] ev_count;

    int        checks = 0;
    int        errors = 0;
    int        ferr_seen = 0;
    int        pop_req = 0;
    int        pop_ack = 0;
    bit        auto_pop = 1'b0;
    logic [9:0] exp_q[$];

    ps2_key_event_rx #(
        .CLK_HZ(1_000_000),
        .TIMEOUT_US(120),
        .FIFO_DEPTH(DEPTH),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_valid(ev_valid), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_rel(ev_rel), .frame_err(frame_err),
        .overflow(overflow), .ev_count(ev_count)
    );

    always #500 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (frame_err) ferr_seen++;
        if (!rst && ev_valid && (auto_pop || pop_req != pop_ack)) begin
            if (pop_req != pop_ack) pop_ack++;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {ev_ext, ev_rel, ev_code}, 10'h3FF);
            end else begin
                e = exp_q.pop_front();
                chk("event", {ev_ext, ev_rel, ev_code}, e);
            end
            rd_en = 1'b1;
        end else begin
            rd_en = 1'b0;
        end
    end

    // mode 1: check latency at the stop bit; mode 2: request a pop coinciding with the push
    task automatic send_bits(input logic [7:0] code, input bit bad, input int nbits, input int mode);
        logic [10:0] f;
        int n;
        f = {1'b1, (~^code) ^ bad, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            n = 0;
            if (i == 10 && mode == 1) begin
                repeat (S + 2) @(posedge clk);
                #1 chk("latency_early", ev_valid, 0);
                @(posedge clk);
                #1 chk("latency_valid", ev_valid, 1);
                chk("first_code", ev_code, 8'h1C);
                chk("first_ext", ev_ext, 0);
                chk("first_rel", ev_rel, 0);
                chk("first_count", ev_count, 1);
                @(negedge clk);
                n = S + 3;
            end else if (i == 10 && mode == 2) begin
                repeat (S + 2) @(posedge clk);
                #1 pop_req++;
                @(negedge clk);
                n = S + 2;
            end
            repeat (HALF - n) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] code);
        send_bits(code, 1'b0, 11, 0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #60_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; clr_ovf = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", ev_valid, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_ext", ev_ext, 0);
        chk("rst_rel", ev_rel, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", ev_count, 0);

        exp_q.push_back({2'b00, 8'h1C});
        send_bits(8'h1C, 1'b0, 11, 1);
        auto_pop = 1'b1;
        wait_drain();

        exp_q.push_back({2'b11, 8'h74});
        send(8'hE0); send(8'hF0); send(8'h74);
        wait_drain();

        exp_q.push_back({2'b10, 8'h75});
        send(8'hE0); send(8'h75);
        wait_drain();

        exp_q.push_back({2'b11, 8'h6B});
        send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0); send(8'h6B);
        wait_drain();

        send_bits(8'h1C, 1'b1, 11, 0);
        wait_drain();
        chk("ferr_after_bad", ferr_seen, 1);
        exp_q.push_back({2'b01, 8'h1C});
        send(8'hF0); send(8'h1C);
        wait_drain();
        chk("ferr_after_rel", ferr_seen, 1);

        send_bits(8'h12, 1'b0, 5, 0);
        repeat (130) @(negedge clk);
        exp_q.push_back({2'b00, 8'h29});
        send(8'h29);
        wait_drain();
        chk("ferr_after_timeout", ferr_seen, 1);

        auto_pop = 1'b0;
        exp_q.push_back({2'b00, 8'h15}); send(8'h15);
        exp_q.push_back({2'b00, 8'h1D}); send(8'h1D);
        exp_q.push_back({2'b00, 8'h24}); send(8'h24);
        exp_q.push_back({2'b00, 8'h2D}); send(8'h2D);
        send(8'h2C);
        repeat (10) @(negedge clk);
        chk("full_count", ev_count, DEPTH);
        chk("overflow_set", overflow, 1);
        chk("full_head", ev_code, 8'h15);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("overflow_clr", overflow, 0);
        chk("count_after_clr", ev_count, DEPTH);

        exp_q.push_back({2'b00, 8'h35});
        send_bits(8'h35, 1'b0, 11, 2);
        chk("pushpop_count", ev_count, DEPTH);
        chk("pushpop_ovf", overflow, 0);
        auto_pop = 1'b1;
        wait_drain();
        chk("empty_valid", ev_valid, 0);
        chk("empty_code", ev_code, 0);
        chk("empty_count", ev_count, 0);

        auto_pop = 1'b0;
        send(8'h5A);
        chk("pre_reset_count", ev_count, 1);
        send_bits(8'h33, 1'b0, 6, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("flush_count", ev_count, 0);
        chk("flush_valid", ev_valid, 0);
        auto_pop = 1'b1;
        exp_q.push_back({2'b00, 8'h1B});
        send(8'h1B);
        wait_drain();
        chk("ferr_final", ferr_seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver that turns raw PS/2 frames into complete key events with make/break and extended-key flags, buffered in an on-chip FIFO. It sits between the board PS/2 pins and the game/console logic. Consumers pop whole events instead of tracking F0/E0 prefixes themselves. It adds a generic timeout, frame-error reporting, event queuing and overflow detection.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- TIMEOUT_US, 120, PS/2 clock inactivity (µs) that aborts a partial frame
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, flops in each pin synchroniser; ≥2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ps2_clk  in  1  PS/2 clock pin, asynchronous
- ps2_data  in  1  PS/2 data pin, asynchronous
- rd_en  in  1  pop head event; ignored when ev_valid=0
- clr_ovf  in  1  clears overflow sticky bit
- ev_valid  out  1  FIFO non-empty; head event presented
- ev_code  out  8  head event scancode byte
- ev_ext  out  1  head event was E0-prefixed
- ev_rel  out  1  head event was F0-prefixed (break)
- frame_err  out  1  one-cycle pulse per rejected frame
- overflow  out  1  sticky: event dropped because FIFO was full
- ev_count  out  $clog2(FIFO_DEPTH+1)  events currently queued

## Operation
- Both pins pass through SYNC_STAGES flops, with reset value 1. A falling edge is detected on the synchronised ps2_clk.
- Frame reception:
  - Every falling edge shifts ps2_data into an 11-bit LSB-first register and increments bit_cnt (0..11).
  - At bit_cnt=11 the frame completes and is checked: start=0, stop=1, odd parity over data+parity bit.
- Timeout:
  - TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US. The timer clears on every ps2_clk edge and saturates at TIMEOUT_CYC.
  - When the timer reaches TIMEOUT_CYC with 0<bit_cnt<11 and ps2_clk high, bit_cnt clears and the partial frame is discarded.
  - A timeout does not produce frame_err.
- Prefix FSM, states IDLE, EXT, REL, EXT_REL:
  - Good byte E0: IDLE→EXT.
  - Good byte F0: IDLE→REL, EXT→EXT_REL.
  - Any other good byte: push {ext,rel,code}, where ext and rel follow the current state, then →IDLE.
  - E0 received in EXT, or F0 received in REL/EXT_REL, is absorbed with no state change.
  - A bad frame pulses frame_err and returns the FSM to IDLE with no push.
  - A timeout returns the FSM to IDLE.
- FIFO behaviour:
  - The FIFO is show-ahead: ev_code, ev_ext and ev_rel show the head entry whenever ev_valid=1, and are 0 when empty.
  - Push while full: the event is dropped and overflow is set. A simultaneous pop frees the slot, so the push succeeds with no overflow.
  - Push and pop in the same cycle while not full: ev_count is unchanged.
  - clr_ovf clears overflow. If a drop occurs in the same cycle, set wins.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty is decided from ev_count.

## Timing
- Reset values: ev_valid=0, ev_code=0, ev_ext=0, ev_rel=0, frame_err=0, overflow=0, ev_count=0. FSM=IDLE, bit_cnt=0, timer=0, FIFO empty.
- Reset asserted mid-frame aborts the frame and flushes the FIFO. After release, reception restarts at the next falling edge of ps2_clk.
- Latency: ev_valid rises exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples the stop-bit falling edge at the pin.
- frame_err pulses on the same cycle a good frame would have pushed.
- Pop: ev_valid/ev_code update on the clk edge after rd_en=1, showing the next entry or going low.
- Input assumptions: ps2_clk runs at 10–33 kHz, and CLK_HZ ≥ 1 MHz.

## Structure
- Package ps2_pkg holds:
  - constants PS2_FRAME_BITS=11, PS2_EXT_CODE=8'hE0, PS2_REL_CODE=8'hF0;
  - the prefix FSM state enum;
  - the 10-bit event type {ext, rel, code[7:0]}.
- Sub-module ps2_event_fifo (parametrised depth and width, show-ahead, count output) holds the FIFO. The synchroniser, frame receiver and prefix FSM stay in the top module.

## Test plan
- Frame 0x1C with good parity → ev_valid=1 after SYNC_STAGES+2 cycles; ev_code=0x1C, ev_ext=0, ev_rel=0, ev_count=1.
- Sequence E0,F0,74 → exactly one event: code=0x74, ext=1, rel=1. No events are pushed for the prefixes.
- Frame 0x1C with parity flipped, then F0,1C → one frame_err pulse, then one event 0x1C with rel=1. The bad frame does not leave a pending prefix.
- 5 bits of a frame, then ps2_clk idle for TIMEOUT_US+10 µs, then full frame 0x29 → one event 0x29, no frame_err.
- FIFO_DEPTH+1 events with no reads → ev_count=FIFO_DEPTH and overflow=1. The first FIFO_DEPTH codes pop in order. clr_ovf clears overflow.
- FIFO full, with a push and rd_en in the same cycle → no overflow, ev_count unchanged, and the new code ends up at the tail.
